shift_add_multiplier_8bit: RTL and testbench
============================================

# shift_add_multiplier_8bit

Sequential 8x8 unsigned multiplier built around the team's 8-bit carry look-ahead adder (`carry_look_ahead_adder`), which performs every partial-product addition. The block sits directly upstream of that adder: it sequences operands into it one iteration per cycle and consumes its sum and carry-out. A start/busy/done handshake lets a controller issue multiplications and collect a 16-bit product 8 cycles after acceptance.

## Interface
- No parameters; operand width is fixed at 8 bits, matching the adder.
- clk  input  1  rising-edge clock; the block has only this one clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiplication; sampled on the rising edge of clk.
- a  input  8  multiplicand, unsigned; sampled only on the edge that accepts start.
- b  input  8  multiplier, unsigned; sampled only on the edge that accepts start.
- busy  output  1  high while iterations are in progress (CALC state).
- done  output  1  one-cycle pulse; product is valid and newly updated.
- product  output  16  result register, holds the last completed product.

## Operation
- Internal registers:
  - M[7:0], the latched multiplicand.
  - Acc[7:0], the accumulator.
  - Q[7:0], the shifting multiplier and low half of the result.
  - C, the carry bit.
  - cnt[2:0], the iteration count.
  - state, one of IDLE, CALC, DONE.
- Adder usage: the adder instance is fed Acc and M with carry_in = 0. It produces the sum S[7:0] and carry_out.
- On acceptance: M<=a, Q<=b, Acc<=0, C<=0, cnt<=0, state<=CALC.
- Each CALC cycle:
  - If Q[0]=1, form {C,Acc} = {carry_out,S}. Otherwise form {C,Acc} = {0,Acc}.
  - Then shift right: {C,Acc,Q} <= {0, newC, newAcc, Q[7:1]}, written as a 17-bit right shift by one of {newC,newAcc,Q}.
  - cnt <= cnt+1.
- When cnt=7 in CALC, the iteration is performed and then:
  - product <= {Acc,Q}, the post-shift value.
  - state <= DONE.
- State transitions:
  - IDLE: if start, go to CALC and accept operands. Otherwise stay in IDLE.
  - CALC: stay for exactly 8 cycles, then go to DONE. start is ignored, and a and b may change freely.
  - DONE: if start, go to CALC and accept operands (back-to-back issue). Otherwise go to IDLE.
- Outputs:
  - busy = (state==CALC).
  - done = (state==DONE).
  - product is registered and changes only on the transition into DONE or on reset.
- Arithmetic: the result is exact for all operand values. The maximum product is 0xFF*0xFF = 0xFE01, and no overflow is possible in 16 bits.
- Reset: when reset=1 at an edge, the following are cleared on that edge, regardless of state, including mid-CALC:
  - state=IDLE, busy=0, done=0, product=0x0000.
  - M, Acc, Q, C and cnt are all cleared to 0.
  - reset has priority over start.

## Timing
- Reset values: busy=0, done=0, product=0x0000.
- Edge E0 accepts start. Edges E1..E8 perform iterations 0..7.
- After E8, done=1 and product is valid for the full cycle.
- Latency is 8 clock cycles from the accepting edge to done rising.
- busy is high in the 8 cycles following E0 and is low while done is high.
- done is high for exactly one cycle, unless start is held: in that case the DONE→CALC transition still gives exactly a one-cycle pulse.
- Throughput: with start held high, a new operation is accepted every 9 cycles (at E0, E9, E18, ...).
- product holds its value through subsequent CALC phases until the next completion.

## Test plan
- After reset, drive a=0x0D, b=0x0B and pulse start for 1 cycle → busy high for 8 cycles, then done pulse for 1 cycle with product=0x008F; product stays 0x008F afterwards.
- Corner operands:
  - 0xFF*0xFF → product=0xFE01.
  - 0x00*0x5A → product=0x0000.
  - 0x80*0x02 → product=0x0100.
  - 0x01*0xFF → product=0x00FF.
- Operand and start disturbance: accept a=0x12, b=0x34; then during CALC toggle start and change a/b randomly → exactly one done, 8 cycles after acceptance, with product=0x03A8 and no extra accept.
- start held high with operands updated each accept: (0x03,0x05), then (0x10,0x10), then (0xFF,0x01) → done pulses at cycles 8, 17 and 26 after the first accept, with products 0x000F, 0x0100 and 0x00FF.
- Reset mid-operation: accept 0xAA*0x55, then assert reset on the 4th CALC cycle → next cycle busy=0, done=0, product=0x0000, and no done pulse follows.
- After the mid-operation reset, restart with 0xAA*0x55 → product=0x3872.
- Random regression: 1000 random a/b pairs compared against a*b → all products match and each done arrives exactly 8 cycles after acceptance.

Source files
------------

// File: rtl/shift_add_multiplier_8bit.sv
// 8-bit carry look-ahead adder plus a sequential 8x8 unsigned shift-add
// multiplier that drives every partial-product addition through it.

module carry_look_ahead_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       carry_in,
   output logic [7:0] sum,
   output logic       carry_out
);

   logic [7:0] gen;
   logic [7:0] prop;
   logic [8:0] carry;

   // Carry into bit (idx+1), expanded as a flat sum of generate/propagate
   // products so no carry depends on a lower computed carry.
   function automatic logic lookahead(input logic [7:0] g,
                                      input logic [7:0] p,
                                      input logic       cin,
                                      input int         idx);
      logic chain;
      logic c;
      chain = 1'b1;
      c     = 1'b0;
      for (int j = 7; j >= 0; j--) begin
         if (j <= idx) begin
            c     = c | (chain & g[j]);
            chain = chain & p[j];
         end
      end
      return c | (chain & cin);
   endfunction

   assign gen  = a & b;
   assign prop = a ^ b;

   // All carries are computed in parallel from generate/propagate terms.
   always_comb begin
      // NOTE: every bit gets a value on every pass through the block, so no latch is inferred.
      carry    = '0;
      carry[0] = carry_in;
      for (int i = 0; i < 8; i++) begin
         carry[i+1] = lookahead(gen, prop, carry_in, i);
      end
   end

   assign sum       = prop ^ carry[7:0];
   assign carry_out = carry[8];

endmodule


module shift_add_multiplier_8bit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [7:0]  m_reg;
   logic [7:0]  acc;
   logic [7:0]  q;
   logic        c;
   logic [2:0]  cnt;

   logic [7:0]  add_sum;
   logic        add_carry;
   logic [8:0]  partial;
   logic [16:0] shifted;
   logic        accept;
   logic        last_iter;

   carry_look_ahead_adder u_adder (
      .a         (acc),
      .b         (m_reg),
      .carry_in  (1'b0),
      .sum       (add_sum),
      .carry_out (add_carry)
   );

   // Conditional add of the multiplicand, then a 17-bit right shift of {C,Acc,Q}.
   always_comb begin
      partial = {1'b0, acc};
      if (q[0]) begin
         partial = {add_carry, add_sum};
      end
      shifted = {partial, q} >> 1;
   end

   assign accept    = start && (state == IDLE || state == DONE);
   assign last_iter = (state == CALC) && (cnt == 3'd7);

   // Next-state decode and status outputs.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == 3'd7) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? CALC : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Datapath: operand capture, one shift-add iteration per CALC cycle, result capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_reg   <= '0;
         acc     <= '0;
         q       <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         m_reg <= a;
         q     <= b;
         acc   <= '0;
         c     <= 1'b0;
         cnt   <= '0;
      end else if (state == CALC) begin
         c   <= shifted[16];
         acc <= shifted[15:8];
         q   <= shifted[7:0];
         cnt <= cnt + 3'd1;
         if (last_iter) begin
            product <= shifted[15:0];
         end
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Directed and random checks for the sequential shift-add multiplier.

module tb_shift_add_multiplier_8bit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int n_checks;
   int n_fail;
   logic [15:0] last_exp;

   shift_add_multiplier_8bit dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one multiplication and check latency, busy length, hold and result.
   task automatic issue(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [15:0] exp, input string tag);
      int lat;
      int busy_cnt;
      start = 1'b1;
      a     = op_a;
      b     = op_b;
      step();
      start = 1'b0;
      check({tag, "_busy0"}, busy, 1);
      check({tag, "_hold"}, product, last_exp);
      busy_cnt = 1;
      lat      = 0;
      while (!done && lat < 20) begin
         step();
         lat++;
         if (busy) busy_cnt++;
      end
      check({tag, "_lat"}, lat, 8);
      check({tag, "_busylen"}, busy_cnt, 8);
      check({tag, "_prod"}, product, exp);
      last_exp = exp;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      int done_k [3];
      logic [15:0] done_p [3];
      logic [7:0] ra;
      logic [7:0] rb;

      n_checks = 0;
      n_fail   = 0;
      last_exp = 16'h0000;
      reset    = 1'b1;
      start    = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_prod", product, 16'h0000);
      reset = 1'b0;
      step();

      // Basic operation and product hold afterwards.
      issue(8'h0D, 8'h0B, 16'h008F, "basic");
      check("basic_busy_at_done", busy, 0);
      step();
      check("basic_done_pulse", done, 0);
      check("basic_after", product, 16'h008F);
      step();
      check("basic_after2", product, 16'h008F);

      // Corner operands.
      issue(8'hFF, 8'hFF, 16'hFE01, "ffxff");
      issue(8'h00, 8'h5A, 16'h0000, "zero");
      issue(8'h80, 8'h02, 16'h0100, "msb");
      issue(8'h01, 8'hFF, 16'h00FF, "onexff");
      step();

      // Disturb start and operands during CALC.
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      step();
      dones = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k <= 7) begin
            start = 1'($urandom_range(0, 1));
            a     = 8'($urandom);
            b     = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         step();
         if (done) begin
            dones++;
            check("dist_lat", k, 8);
            check("dist_prod", product, 16'h03A8);
         end
      end
      check("dist_dones", dones, 1);
      check("dist_idle", busy, 0);
      last_exp = 16'h03A8;

      // start held high: back-to-back accepts every 9 cycles.
      start = 1'b1;
      a     = 8'h03;
      b     = 8'h05;
      step();
      a     = 8'h10;
      b     = 8'h10;
      dones = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 9) begin
            a = 8'hFF;
            b = 8'h01;
         end
         if (k == 26) start = 1'b0;
         if (done) begin
            if (dones < 3) begin
               done_k[dones] = k;
               done_p[dones] = product;
            end
            dones++;
         end
      end
      check("held_dones", dones, 3);
      if (dones >= 3) begin
         check("held_k0", done_k[0], 8);
         check("held_p0", done_p[0], 16'h000F);
         check("held_k1", done_k[1], 17);
         check("held_p1", done_p[1], 16'h0100);
         check("held_k2", done_k[2], 26);
         check("held_p2", done_p[2], 16'h00FF);
      end
      last_exp = 16'h00FF;

      // Reset on the 4th CALC cycle.
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'h55;
      step();
      start = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_prod", product, 16'h0000);
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done) dones++;
      end
      check("midrst_nodone", dones, 0);
      last_exp = 16'h0000;

      issue(8'hAA, 8'h55, 16'h3872, "restart");
      step();

      // Random regression against a*b.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         issue(ra, rb, 16'(ra) * 16'(rb), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
